// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture path: FSM encoding, throttle
// mapping constants and the default microsecond limits of the PWM scale.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // throttle = ((w - THR_MIN) * THR_MULT + THR_ROUND) >> THR_SHIFT
  localparam int THR_MULT  = 327;
  localparam int THR_SHIFT = 10;
  localparam int THR_ROUND = 512;

  localparam int DEF_CLK_PER_US    = 50;
  localparam int DEF_CTR_LEN       = 12;
  localparam int DEF_MIN_VALID_US  = 800;
  localparam int DEF_MAX_VALID_US  = 2200;
  localparam int DEF_THR_MIN_US    = 1064;
  localparam int DEF_IDLE_US       = 900;
  localparam int DEF_TIMEOUT_US    = 25000;
  localparam int DEF_FILTER_CYCLES = 4;

endpackage

// File: rtl/pwm_capture_sync.sv
// Two-flop synchronizer for the PWM pin with edge detection; an optional
// glitch filter is enabled by defining PWM_IN_GLITCH_FILTER_EN.
module pwm_in_sync #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_meta;
  logic sync_out;
  logic level_q;
  logic level_d;

  if (FILTER_CYCLES < 2) begin : g_filter_len_check
    $error("pwm_in_sync: FILTER_CYCLES must be at least 2");
  end

  // The data stages are not reset so they already track the pin when reset
  // releases; otherwise a pin held high would look like a fresh low.
  always_ff @(posedge clock) begin
    sync_meta <= pwm_in;
    sync_out  <= sync_meta;
  end

`ifdef PWM_IN_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYCLES);
  logic [FW-1:0] stable_cnt;

  always_ff @(posedge clock) begin
    if (sync_out == level_q) begin
      stable_cnt <= '0;
    end else if (stable_cnt == FW'(FILTER_CYCLES - 1)) begin
      level_q    <= sync_out;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end
`else
  assign level_q = sync_out;
`endif

  always_ff @(posedge clock) begin
    if (!reset) level_d <= 1'b0;
    else        level_d <= level_q;
  end

  assign level = level_q;
  assign rise  = level_q & ~level_d;
  assign fall  = ~level_q & level_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM high time in microseconds, validates it and maps it to an
// 8-bit throttle; loss-of-signal forces idle. Option: PWM_IN_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CLK_PER_US    = DEF_CLK_PER_US,
  parameter int CTR_LEN       = DEF_CTR_LEN,
  parameter int MIN_VALID_US  = DEF_MIN_VALID_US,
  parameter int MAX_VALID_US  = DEF_MAX_VALID_US,
  parameter int THR_MIN_US    = DEF_THR_MIN_US,
  parameter int IDLE_US       = DEF_IDLE_US,
  parameter int TIMEOUT_US    = DEF_TIMEOUT_US,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pwm_in,
  output logic [CTR_LEN-1:0] pulse_us,
  output logic [7:0]         throttle_setting,
  output logic               valid,
  output logic               new_sample,
  output logic               pulse_err,
  output logic               signal_lost
);

  localparam int PRE_W = $clog2(CLK_PER_US);
  localparam logic [CTR_LEN-1:0] MIN_W  = CTR_LEN'(MIN_VALID_US);
  localparam logic [CTR_LEN-1:0] MAX_W  = CTR_LEN'(MAX_VALID_US);
  localparam logic [CTR_LEN-1:0] OVF_W  = CTR_LEN'(MAX_VALID_US + 1);
  localparam logic [CTR_LEN-1:0] THR0_W = CTR_LEN'(THR_MIN_US);
  localparam logic [CTR_LEN-1:0] IDLE_W = CTR_LEN'(IDLE_US);
  localparam logic [PRE_W-1:0]   PRE_END = PRE_W'(CLK_PER_US - 1);

  logic level, rise, fall;
  state_t state, state_next;
  logic width_clear, capture, err;
  logic [PRE_W-1:0] us_cnt, to_pre;
  logic us_tick, to_tick;
  logic [CTR_LEN-1:0] width_cnt, width_eff, cap_width;
  logic cap_stb;
  logic [15:0] to_cnt;
  logic to_hit;
  logic [CTR_LEN-1:0] thr_diff;
  logic [18:0] thr_prod;
  logic [8:0] thr_scaled;
  logic [7:0] thr_value;

  pwm_in_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync (
    .clock  (clock),
    .reset  (reset),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign us_tick = (us_cnt == PRE_END);
  assign to_tick = (to_pre == PRE_END);
  // Include the tick landing on the edge cycle so an N us pulse reads as N.
  assign width_eff = width_cnt + CTR_LEN'(us_tick);
  assign to_hit = (to_cnt == 16'(TIMEOUT_US));

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_ARM;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    width_clear = 1'b0;
    capture     = 1'b0;
    err         = 1'b0;
    unique case (state)
      ST_ARM: if (!level) state_next = ST_LOW;
      ST_LOW: if (rise) begin
        state_next  = ST_HIGH;
        width_clear = 1'b1;
      end
      ST_HIGH: begin
        if (fall) begin
          if (width_eff > MAX_W) begin
            err        = 1'b1;
            state_next = ST_ARM;
          end else if (width_eff < MIN_W) begin
            err        = 1'b1;
            state_next = ST_LOW;
          end else begin
            capture    = 1'b1;
            state_next = ST_LOW;
          end
        end else if (us_tick && width_eff == OVF_W) begin
          err        = 1'b1;
          state_next = ST_ARM;
        end
      end
      default: state_next = ST_ARM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      us_cnt    <= '0;
      to_pre    <= '0;
      width_cnt <= '0;
      cap_width <= '0;
      cap_stb   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      us_cnt    <= (width_clear || us_tick) ? '0 : us_cnt + 1'b1;
      to_pre    <= to_tick ? '0 : to_pre + 1'b1;
      if (width_clear)                     width_cnt <= '0;
      else if (state == ST_HIGH && us_tick) width_cnt <= width_cnt + 1'b1;
      if (capture) cap_width <= width_eff;
      cap_stb <= capture;
      if (cap_stb)               to_cnt <= '0;
      else if (to_tick && !to_hit) to_cnt <= to_cnt + 16'd1;
    end
  end

  always_comb begin
    thr_diff   = cap_width - THR0_W;
    thr_prod   = 19'(thr_diff) * 19'(THR_MULT) + 19'(THR_ROUND);
    thr_scaled = 9'(thr_prod >> THR_SHIFT);
    if (cap_width <= THR0_W)       thr_value = 8'd0;
    else if (thr_scaled > 9'd255)  thr_value = 8'd255;
    else                           thr_value = thr_scaled[7:0];
  end

  // A sample landing in the same cycle as the timeout takes priority.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pulse_us         <= IDLE_W;
      throttle_setting <= 8'd0;
      valid            <= 1'b0;
      new_sample       <= 1'b0;
      pulse_err        <= 1'b0;
      signal_lost      <= 1'b1;
    end else begin
      new_sample <= cap_stb;
      pulse_err  <= err;
      if (cap_stb) begin
        pulse_us         <= cap_width;
        throttle_setting <= thr_value;
        valid            <= 1'b1;
        signal_lost      <= 1'b0;
      end else if (to_hit) begin
        pulse_us         <= IDLE_W;
        throttle_setting <= 8'd0;
        valid            <= 1'b0;
        signal_lost      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture, run with a 2-cycle microsecond and a
// shortened timeout so whole pulses fit in a short simulation.
module tb_pwm_capture;

  localparam int CPU  = 2;
  localparam int TOUT = 3000;
`ifdef PWM_IN_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic pwm_in;
  logic [11:0] pulse_us;
  logic [7:0] throttle_setting;
  logic valid, new_sample, pulse_err, signal_lost;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ns_cnt = 0, pe_cnt = 0;
  int last_ns_cyc = 0, last_pe_cyc = 0;
  int drive_cyc = 0;
  int ns0, pe0, edge_cyc, t0;

  pwm_capture #(.CLK_PER_US(CPU), .TIMEOUT_US(TOUT)) dut (
    .clock            (clock),
    .reset            (reset),
    .pwm_in           (pwm_in),
    .pulse_us         (pulse_us),
    .throttle_setting (throttle_setting),
    .valid            (valid),
    .new_sample       (new_sample),
    .pulse_err        (pulse_err),
    .signal_lost      (signal_lost)
  );

  always #5 clock = ~clock;

  // Strobe recorder, sampling 1 time unit after each rising edge.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (new_sample) begin ns_cnt++; last_ns_cyc = cyc; end
    if (pulse_err)  begin pe_cnt++; last_pe_cyc = cyc; end
  end

  task automatic applyStimulus(input logic lvl, input int us);
    drive_cyc = cyc;
    pwm_in = lvl;
    repeat (us * CPU) @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic samplePulse(input int us, input int exp_thr, input bit check_lat);
    ns0 = ns_cnt;
    pe0 = pe_cnt;
    applyStimulus(1'b1, us);
    applyStimulus(1'b0, 100);
    edge_cyc = drive_cyc;
    checkOutput($sformatf("samples_%0d", us), ns_cnt - ns0, 1);
    checkOutput($sformatf("errors_%0d", us), pe_cnt - pe0, 0);
    if (check_lat) checkOutput("sample_latency", last_ns_cyc - edge_cyc, 4 + LAT);
    checkOutput($sformatf("pulse_us_%0d", us), pulse_us, us);
    checkOutput($sformatf("throttle_%0d", us), throttle_setting, exp_thr);
    checkOutput($sformatf("valid_%0d", us), valid, 1);
    checkOutput($sformatf("lost_%0d", us), signal_lost, 0);
  endtask

  initial begin
    pwm_in = 1'b1;
    reset  = 1'b0;
    @(negedge clock);
    repeat (20) @(negedge clock);
    checkOutput("rst_pulse_us", pulse_us, 900);
    checkOutput("rst_throttle", throttle_setting, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_new_sample", new_sample, 0);
    checkOutput("rst_pulse_err", pulse_err, 0);
    checkOutput("rst_signal_lost", signal_lost, 1);

    // Pin already high at release: that partial pulse must be ignored.
    reset = 1'b1;
    ns0 = ns_cnt;
    pe0 = pe_cnt;
    applyStimulus(1'b1, 300);
    applyStimulus(1'b0, 100);
    checkOutput("partial_samples", ns_cnt - ns0, 0);
    checkOutput("partial_errors", pe_cnt - pe0, 0);

    samplePulse(1500, 139, 1'b1);
    samplePulse(1064, 0, 1'b0);
    samplePulse(1864, 255, 1'b0);
    samplePulse(2000, 255, 1'b0);
    samplePulse(1000, 0, 1'b0);
    samplePulse(800, 0, 1'b0);
    samplePulse(2200, 255, 1'b0);

    samplePulse(1500, 139, 1'b0);
    ns0 = ns_cnt;
    pe0 = pe_cnt;
    applyStimulus(1'b1, 700);
    applyStimulus(1'b0, 100);
    edge_cyc = drive_cyc;
    checkOutput("short_errors", pe_cnt - pe0, 1);
    checkOutput("short_err_latency", last_pe_cyc - edge_cyc, 3 + LAT);
    checkOutput("short_samples", ns_cnt - ns0, 0);
    checkOutput("short_hold_pulse_us", pulse_us, 1500);
    checkOutput("short_hold_throttle", throttle_setting, 139);

    // Held high past the maximum: error at the 2201st us, then re-arm.
    ns0 = ns_cnt;
    pe0 = pe_cnt;
    applyStimulus(1'b1, 2300);
    edge_cyc = drive_cyc;
    applyStimulus(1'b0, 100);
    checkOutput("ovf_errors", pe_cnt - pe0, 1);
    checkOutput("ovf_err_latency", last_pe_cyc - edge_cyc, 2201 * CPU + 3 + LAT);
    checkOutput("ovf_samples", ns_cnt - ns0, 0);
    samplePulse(1500, 139, 1'b0);

    t0 = last_ns_cyc;
    while (cyc < t0 + TOUT * CPU - 10) @(negedge clock);
    checkOutput("pre_timeout_valid", valid, 1);
    checkOutput("pre_timeout_lost", signal_lost, 0);
    while (cyc < t0 + TOUT * CPU + 10) @(negedge clock);
    checkOutput("timeout_lost", signal_lost, 1);
    checkOutput("timeout_valid", valid, 0);
    checkOutput("timeout_pulse_us", pulse_us, 900);
    checkOutput("timeout_throttle", throttle_setting, 0);
    samplePulse(1500, 139, 1'b0);

    // 2-cycle low glitch in the middle of a 1500 us pulse.
    samplePulse(1200, 43, 1'b0);
    ns0 = ns_cnt;
    pe0 = pe_cnt;
    applyStimulus(1'b1, 750);
    pwm_in = 1'b0;
    repeat (2) @(negedge clock);
    applyStimulus(1'b1, 749);
    applyStimulus(1'b0, 100);
`ifdef PWM_IN_GLITCH_FILTER_EN
    checkOutput("glitch_samples", ns_cnt - ns0, 1);
    checkOutput("glitch_errors", pe_cnt - pe0, 0);
    checkOutput("glitch_pulse_us", pulse_us, 1500);
`else
    checkOutput("glitch_samples", ns_cnt - ns0, 0);
    checkOutput("glitch_errors", pe_cnt - pe0, 2);
    checkOutput("glitch_pulse_us", pulse_us, 1200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the PWM generator: measures the high time of one RC-receiver/ESC-style PWM input in microseconds, validates it, and converts it back to an 8-bit throttle setting on the same 1064–1864 µs scale the throttle-to-PWM path uses. One instance sits per input channel, between the FPGA pin and the flight controller's command registers. It also provides loss-of-signal detection that forces an idle/failsafe value.

## Interface
- CLK_PER_US, 50: clock cycles per microsecond (50 MHz clock).
- CTR_LEN, 12: width of pulse measurement in µs.
- MIN_VALID_US, 800: shortest accepted pulse.
- MAX_VALID_US, 2200: longest accepted pulse.
- THR_MIN_US, 1064: pulse width mapped to throttle 0.
- IDLE_US, 900: failsafe value driven on pulse_us.
- TIMEOUT_US, 25000: loss-of-signal time since last accepted sample.
- FILTER_CYCLES, 4: glitch-filter stability length (used only with the macro).

- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset (low = reset).
- pwm_in  in  1  asynchronous PWM input pin.
- pulse_us  out  CTR_LEN  last accepted high time, µs.
- throttle_setting  out  8  throttle derived from pulse_us.
- valid  out  1  a fresh sample was accepted within TIMEOUT_US.
- new_sample  out  1  one-cycle strobe when pulse_us/throttle_setting update.
- pulse_err  out  1  one-cycle strobe on a rejected pulse.
- signal_lost  out  1  timeout flag.

## Operation
- pwm_in passes through a 2-flop synchronizer. Edges are detected on the synchronized value.
- A µs prescaler counts 0..CLK_PER_US-1 and emits a tick. It restarts at every accepted rising edge.
- FSM states:
  - ARM: wait for synchronized low, then go to LOW. Entered from reset and after any error, so a partial pulse is never measured.
  - LOW: on a rising edge, clear the width counter and go to HIGH.
  - HIGH: the width counter increments on each tick.
    - Falling edge with MIN_VALID_US ≤ width ≤ MAX_VALID_US: go to LOW and launch a conversion.
    - Falling edge with width < MIN_VALID_US: pulse_err, go to LOW.
    - Width reaches MAX_VALID_US+1 while still high: pulse_err, go to ARM.
- Conversion, with w = width:
  - w ≤ THR_MIN_US gives 0.
  - Otherwise throttle = min(255, ((w−THR_MIN_US)·327 + 512) >> 10).
  - Unsigned arithmetic. The product fits in 19 bits; the shifted result is 9 bits, clamped to 255.
- Timeout counter (16 bits, µs ticks from a free-running prescaler):
  - Cleared on every new_sample.
  - Saturates at TIMEOUT_US.
  - On reaching TIMEOUT_US: signal_lost=1, valid=0, pulse_us=IDLE_US, throttle_setting=0.
  - The FSM keeps running.
- Rejected pulses do not touch outputs or the timeout counter.

## Timing
- Reset values: pulse_us=IDLE_US, throttle_setting=0, valid=0, new_sample=0, pulse_err=0, signal_lost=1. FSM=ARM, all counters 0.
- Synchronizer latency is 2 cycles. It is applied equally to both edges, so measured width is truncated to whole µs (±1 µs).
- Falling edge detected in cycle F:
  - F+1: width registered.
  - F+2: pulse_us, throttle_setting, valid=1, signal_lost=0 and new_sample=1 together, for exactly one cycle.
- pulse_err is asserted in the cycle after the offending edge or overflow tick.
- Timeout and new_sample in the same cycle: the sample wins, and signal_lost stays/clears to 0.
- Reset asserted mid-pulse: all state is set to reset values on the next edge. After release, a low must be seen before measuring.
- A rising edge that arrives while a conversion is in flight (F+1) is accepted normally; the pipeline is not stalled.

## Configuration
- PWM_IN_GLITCH_FILTER_EN defined:
  - After the synchronizer, the filtered level changes only after FILTER_CYCLES consecutive equal samples.
  - Adds FILTER_CYCLES cycles of latency to both edges; width is unchanged.
  - Shorter glitches are ignored.
- Undefined: the synchronizer output feeds edge detection directly, and single-cycle glitches are seen as edges.

## Structure
- Shared package holds:
  - FSM state encoding (ARM, LOW, HIGH).
  - Mapping constants: the 327 multiplier, the 10-bit shift, the 512 rounding term.
  - The default µs limits, shared with the throttle-to-PWM path.
- One sub-module, pwm_in_sync: 2-flop synchronizer plus optional glitch filter, outputting level, rise and fall. Everything else stays in pwm_capture.

## Test plan
- Release reset with pwm_in high for 300 µs, then low, then a 1500 µs pulse → first pulse ignored. new_sample at F+2 with pulse_us=1500, throttle_setting=139, valid=1, signal_lost=0.
- Single pulses:
  - 1064 µs → 0.
  - 1864 µs → 255.
  - 2000 µs → 255 (clamp).
  - 1000 µs → 0 with pulse_us=1000.
- 700 µs pulse after a valid 1500 µs sample → pulse_err strobe, no new_sample, outputs hold 1500/139.
- pwm_in held high for 2300 µs → pulse_err at the 2201st µs, FSM in ARM. The next pulse is measured only after a low.
- Valid sample, then no edges for 25 ms → signal_lost=1, valid=0, pulse_us=900, throttle_setting=0. The next 1500 µs pulse restores valid=1 and clears signal_lost.
- 2-cycle low glitch in the middle of a 1500 µs pulse:
  - With PWM_IN_GLITCH_FILTER_EN: one sample, pulse_us=1500.
  - Without: short-pulse pulse_err and/or split measurement, with no 1500 sample.
